sobel_edge: RTL and testbench
=============================

SOBEL_EDGE -- requirements
Module: sobel_edge

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, meaning active pixels per line (range 4..2048).
REQ-002 SHALL have parameter THRESH_RST, default 8'd64, meaning threshold value loaded at reset.
REQ-003 SHALL have one clock and asynchronous active-high reset: clk  in  1  pixel clock; rst  in  1  async active-high reset.
REQ-004 SHALL have data_in  in  8  filtered grey pixel from the median stage.
REQ-005 SHALL have data_in_en  in  1  pixel valid; pipeline advances only when high.
REQ-006 SHALL have hs_in  in  1  line sync; vs_in  in  1  frame sync (active-high).
REQ-007 SHALL have thresh  in  8  edge threshold, sampled per frame.
REQ-008 SHALL have data_out  out  8  edge pixel; data_out_en  out  1  valid; hs_out  out  1; vs_out  out  1.

Function
REQ-009 SHALL build a 3x3 window p[r][c] (r=0 oldest line, c=0 oldest column) from two line delays plus the current line, shifting only on data_in_en.
REQ-010 SHALL compute gx = (p02+2*p12+p22)-(p00+2*p10+p20) and gy = (p20+2*p21+p22)-(p00+2*p01+p02) as 11-bit signed values, no overflow.
REQ-011 SHALL compute mag = |gx|+|gy| as 11-bit unsigned (max 2040).
REQ-012 SHALL be a 3-stage pipeline (window register, gx/gy register, mag/compare register), each stage loading only on data_in_en; latency 3 enabled cycles.
REQ-013 SHALL delay hs_in, vs_in, data_in_en by the same 3 enabled cycles to form hs_out, vs_out, data_out_en.
REQ-014 SHALL output data_out = 8'hFF when mag >= latched threshold, else 8'h00.
REQ-015 SHALL keep a column counter (0..IMG_WIDTH-1) incrementing per enabled pixel, wrapping to 0 after IMG_WIDTH-1, and a line counter incrementing on each wrap, saturating at 2.
REQ-016 SHALL force data_out = 8'h00 for pixels with line counter < 2 or column counter < 2 (window incomplete).
REQ-017 SHALL clear both counters on a vs_in rising edge (detected on clk, independent of data_in_en); a simultaneous enabled pixel counts as column 0.
REQ-018 SHALL latch thresh into the internal threshold register on the vs_in rising edge only; mid-frame thresh changes have no effect until the next frame.
REQ-019 SHALL hold all pipeline contents and outputs unchanged while data_in_en is low.

Reset
REQ-020 SHALL, on rst high, asynchronously clear data_out, data_out_en, hs_out, vs_out, all pipeline registers, counters and the vs edge detector to 0, and load threshold with THRESH_RST.
REQ-021 SHALL, after rst mid-frame, output zeros until two full lines plus two columns follow the next vs_in rising edge.
REQ-022 SHALL not require line-buffer contents to be reset; REQ-016 masks stale data.

Configuration
REQ-023 SHALL support macro SOBEL_MAG_OUT_EN: when defined, data_out = min(mag,255) (saturated magnitude), threshold compare and thresh latch unused; when undefined, binary output per REQ-014.
REQ-024 SHALL keep latency, masking and sync alignment identical in both configurations.

Structure
REQ-025 SHALL place in a shared image-processing package: pixel width constant (8), gradient width constant (11), default IMG_WIDTH, default threshold.
REQ-026 SHALL use one sub-module, sobel_line_buf: parameterised-depth, 8-bit, two-tap shift line delay with clock enable, no reset.

Verification
REQ-027 Flat frame, all pixels 8'd100, thresh 64 -> data_out all 8'h00, data_out_en pattern equals data_in_en delayed 3 enabled cycles.
REQ-028 Vertical step (cols <8 = 0, cols >=8 = 200), IMG_WIDTH 16, thresh 64 -> 8'hFF at output columns 8 and 9 of lines >=2, 8'h00 elsewhere.
REQ-029 Threshold change 64->250 mid-frame with step of REQ-028 (mag 800) -> current frame unchanged; next frame still 8'hFF (800>=250); then thresh 8'hFF with step amplitude 30 (mag 120) -> 8'h00.
REQ-030 data_in_en toggled 1/0 every cycle -> outputs identical to continuous-enable run, only stretched; no output change on disabled cycles.
REQ-031 rst asserted for 2 cycles mid-line 5 -> all outputs 0 immediately (asynchronous), threshold = THRESH_RST, masked zeros until REQ-021 satisfied.
REQ-032 With SOBEL_MAG_OUT_EN, single 8'd255 pixel on zero background -> peak output 8'hFF (saturated), neighbours 8'hFF/8'h00 per mag, latency unchanged.

Source files
------------

// File: rtl/sobel_edge_pkg.sv
// Shared image-processing definitions for the Sobel edge stage.
//   PIX_W          grey pixel width
//   GRAD_W         signed gradient / unsigned magnitude width
//   IMG_WIDTH_DEF  default active pixels per line
//   THRESH_DEF     default edge threshold loaded at reset
// Also provides the pixel/gradient types, the pipeline side-band struct
// and two small arithmetic helpers used by the datapath.
package sobel_edge_pkg;

  localparam int PIX_W = 8;
  localparam int GRAD_W = 11;
  localparam int IMG_WIDTH_DEF = 640;
  localparam logic [PIX_W-1:0] THRESH_DEF = 8'd64;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [GRAD_W-1:0] mag_t;

  // Side-band information travelling with each pixel through the pipeline.
  // mask marks pixels whose 3x3 window is not yet fully inside the frame.
  typedef struct packed {
    logic en;
    logic hs;
    logic vs;
    logic mask;
  } side_t;

  // a + 2*b + c, zero-extended to the gradient width (max 1020, never overflows).
  function automatic grad_t col_sum(input pix_t a, input pix_t b, input pix_t c);
    grad_t ea;
    grad_t eb2;
    grad_t ec;
    ea  = grad_t'({{(GRAD_W - PIX_W){1'b0}}, a});
    eb2 = grad_t'({{(GRAD_W - PIX_W - 1){1'b0}}, b, 1'b0});
    ec  = grad_t'({{(GRAD_W - PIX_W){1'b0}}, c});
    return ea + eb2 + ec;
  endfunction

  // |g| for a gradient in -1020..1020; always representable unsigned.
  function automatic mag_t abs_grad(input grad_t g);
    grad_t neg;
    neg = -g;
    return g[GRAD_W-1] ? mag_t'(neg) : mag_t'(g);
  endfunction

endpackage

// File: rtl/sobel_edge_line_buf.sv
// sobel_line_buf: two-tap line delay for the Sobel window, no reset.
//   clk   in   clock
//   ce    in   shift enable (one pixel per enabled cycle)
//   din   in   WIDTH-bit pixel entering the delay
//   tap1  out  din delayed by DEPTH enabled cycles
//   tap2  out  din delayed by 2*DEPTH enabled cycles
// Both taps are registered reads of inferred RAMs. The first RAM is DEPTH
// deep; the second is fed from the registered tap1 (already one cycle late),
// so it is DEPTH-1 deep to land tap2 exactly one line behind tap1.
// The taps update on the same edge the caller loads din into its window.
module sobel_line_buf #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tap1,
  output logic [WIDTH-1:0] tap2
);

  localparam int AW1 = $clog2(DEPTH);
  localparam int AW2 = $clog2(DEPTH - 1);

  logic [WIDTH-1:0] mem1 [DEPTH];
  logic [WIDTH-1:0] mem2 [DEPTH-1];

  logic [AW1-1:0]   ptr1_q, ptr1_d;
  logic [AW2-1:0]   ptr2_q, ptr2_d;
  logic [WIDTH-1:0] tap1_q, tap2_q;

  // Pointers are unreset; the >= wrap makes any power-up value self-heal.
  always_comb begin
    ptr1_d = ptr1_q;
    ptr2_d = ptr2_q;
    if (ce) begin
      ptr1_d = (ptr1_q >= AW1'(DEPTH - 1)) ? '0 : ptr1_q + 1'b1;
      ptr2_d = (ptr2_q >= AW2'(DEPTH - 2)) ? '0 : ptr2_q + 1'b1;
    end
  end

  // Read-before-write on both RAMs.
  always_ff @(posedge clk) begin
    ptr1_q <= ptr1_d;
    ptr2_q <= ptr2_d;
    if (ce) begin
      tap1_q       <= mem1[ptr1_q];
      mem1[ptr1_q] <= din;
      tap2_q       <= mem2[ptr2_q];
      mem2[ptr2_q] <= tap1_q;
    end
  end

  assign tap1 = tap1_q;
  assign tap2 = tap2_q;

endmodule

// File: rtl/sobel_edge.sv
// sobel_edge: 3x3 Sobel edge detector on a streamed grey image.
//   clk, rst              pixel clock, asynchronous active-high reset
//   data_in, data_in_en   grey pixel and its valid; everything advances on valid
//   hs_in, vs_in          line / frame sync (active-high)
//   thresh                edge threshold, latched on each vs_in rising edge
//   data_out, data_out_en edge pixel and valid, 3 enabled cycles after input
//   hs_out, vs_out        syncs delayed to match data_out
// Pipeline: window register -> gx/gy register -> magnitude/compare register.
// Pixels whose window reaches outside the frame (line < 2 or column < 2),
// or that arrive before the first vs_in edge after reset, output 8'h00.
// Build option: define SOBEL_MAG_OUT_EN to output min(|gx|+|gy|, 255)
// instead of the binary thresholded edge; timing and masking are identical.
module sobel_edge
  import sobel_edge_pkg::*;
#(
  parameter int               IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter logic [PIX_W-1:0] THRESH_RST = THRESH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] data_in,
  input  logic             data_in_en,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic [PIX_W-1:0] thresh,
  output logic [PIX_W-1:0] data_out,
  output logic             data_out_en,
  output logic             hs_out,
  output logic             vs_out
);

  localparam int CW = $clog2(IMG_WIDTH);

  // Line delays supply rows 0 (oldest) and 1 of the newest window column.
  pix_t tap1, tap2;

  sobel_line_buf #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIX_W)
  ) u_line_buf (
    .clk  (clk),
    .ce   (data_in_en),
    .din  (data_in),
    .tap1 (tap1),
    .tap2 (tap2)
  );

  // Frame position and control state
  logic [CW-1:0]    col_q, col_d;
  logic [1:0]       line_q, line_d;
  logic             vs_prev_q, vs_prev_d;
  logic             sync_q, sync_d;      // a vs_in edge has been seen since reset
  logic [PIX_W-1:0] thresh_q, thresh_d;

  // Stage 1: window. Columns 0/1 are local; column 2 of rows 0/1 is the
  // line-buffer tap register, column 2 of row 2 is cur_q.
  pix_t  win_q [3][2];
  pix_t  win_d [3][2];
  pix_t  cur_q, cur_d;
  side_t s1_q, s1_d;

  // Stage 2: gradients
  grad_t gx_q, gx_d, gy_q, gy_d;
  side_t s2_q, s2_d;

  // Stage 3: outputs
  logic [PIX_W-1:0] data_out_q, data_out_d;
  logic             data_out_en_q, data_out_en_d;
  logic             hs_out_q, hs_out_d;
  logic             vs_out_q, vs_out_d;

  // Combinational helpers
  pix_t             p [3][3];
  logic             vs_rise;
  logic [CW-1:0]    pix_col;
  logic [1:0]       pix_line;
  logic             col_wrap;
  grad_t            gx, gy;
  mag_t             mag;
  logic [PIX_W-1:0] edge_val;

  // Full 3x3 view of the window: p[r][c], r=0 oldest line, c=0 oldest column.
  for (genvar gi = 0; gi < 3; gi++) begin : g_win_view
    assign p[gi][0] = win_q[gi][0];
    assign p[gi][1] = win_q[gi][1];
  end
  assign p[0][2] = tap2;
  assign p[1][2] = tap1;
  assign p[2][2] = cur_q;

  always_comb begin
    // vs edge detection runs every clock, regardless of data_in_en.
    vs_rise   = vs_in & ~vs_prev_q;
    vs_prev_d = vs_in;
    sync_d    = sync_q | vs_rise;
    thresh_d  = vs_rise ? thresh : thresh_q;

    // A pixel arriving with the vs edge is column 0 of line 0.
    pix_col  = vs_rise ? '0 : col_q;
    pix_line = vs_rise ? 2'd0 : line_q;
    col_wrap = (pix_col == CW'(IMG_WIDTH - 1));

    col_d  = col_q;
    line_d = line_q;
    if (data_in_en) begin
      col_d  = col_wrap ? '0 : pix_col + 1'b1;
      line_d = (col_wrap && pix_line != 2'd2) ? pix_line + 2'd1 : pix_line;
    end else if (vs_rise) begin
      col_d  = '0;
      line_d = '0;
    end

    // Stage 1
    win_d = win_q;
    cur_d = cur_q;
    s1_d  = s1_q;
    if (data_in_en) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = p[r][1];
        win_d[r][1] = p[r][2];
      end
      cur_d   = data_in;
      s1_d.en = 1'b1;
      s1_d.hs = hs_in;
      s1_d.vs = vs_in;
      s1_d.mask = ~sync_d | (pix_line < 2'd2) | (pix_col < CW'(2));
    end

    // Stage 2
    gx = col_sum(p[0][2], p[1][2], p[2][2]) - col_sum(p[0][0], p[1][0], p[2][0]);
    gy = col_sum(p[2][0], p[2][1], p[2][2]) - col_sum(p[0][0], p[0][1], p[0][2]);
    gx_d = gx_q;
    gy_d = gy_q;
    s2_d = s2_q;
    if (data_in_en) begin
      gx_d = gx;
      gy_d = gy;
      s2_d = s1_q;
    end

    // Stage 3
    mag = abs_grad(gx_q) + abs_grad(gy_q);
`ifdef SOBEL_MAG_OUT_EN
    edge_val = (mag > mag_t'(255)) ? 8'hFF : mag[PIX_W-1:0];
`else
    edge_val = (mag >= mag_t'(thresh_q)) ? 8'hFF : 8'h00;
`endif
    data_out_d    = data_out_q;
    data_out_en_d = data_out_en_q;
    hs_out_d      = hs_out_q;
    vs_out_d      = vs_out_q;
    if (data_in_en) begin
      data_out_d    = s2_q.mask ? 8'h00 : edge_val;
      data_out_en_d = s2_q.en;
      hs_out_d      = s2_q.hs;
      vs_out_d      = s2_q.vs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q     <= '0;
      line_q    <= '0;
      vs_prev_q <= 1'b0;
      sync_q    <= 1'b0;
      thresh_q  <= THRESH_RST;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= '0;
        win_q[r][1] <= '0;
      end
      cur_q         <= '0;
      s1_q          <= '0;
      gx_q          <= '0;
      gy_q          <= '0;
      s2_q          <= '0;
      data_out_q    <= '0;
      data_out_en_q <= 1'b0;
      hs_out_q      <= 1'b0;
      vs_out_q      <= 1'b0;
    end else begin
      col_q         <= col_d;
      line_q        <= line_d;
      vs_prev_q     <= vs_prev_d;
      sync_q        <= sync_d;
      thresh_q      <= thresh_d;
      win_q         <= win_d;
      cur_q         <= cur_d;
      s1_q          <= s1_d;
      gx_q          <= gx_d;
      gy_q          <= gy_d;
      s2_q          <= s2_d;
      data_out_q    <= data_out_d;
      data_out_en_q <= data_out_en_d;
      hs_out_q      <= hs_out_d;
      vs_out_q      <= vs_out_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_out_en = data_out_en_q;
  assign hs_out      = hs_out_q;
  assign vs_out      = vs_out_q;

endmodule

// File: tb/tb_sobel_edge.sv
// Self-checking bench for sobel_edge (IMG_WIDTH = 16).
// A frame-level model stores the image by (line, column), computes the Sobel
// magnitude from the 3x3 neighbourhood directly, and releases each result
// three enabled pixels later; the DUT outputs are compared every cycle.
module tb_sobel_edge;

  localparam int W = 16;
  localparam logic [7:0] TR = 8'd64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'd0;
  logic       data_in_en = 1'b0;
  logic       hs_in = 1'b0;
  logic       vs_in = 1'b0;
  logic [7:0] thresh = 8'd64;
  logic [7:0] data_out;
  logic       data_out_en, hs_out, vs_out;

  sobel_edge #(.IMG_WIDTH(W), .THRESH_RST(TR)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_en(data_in_en),
    .hs_in(hs_in), .vs_in(vs_in), .thresh(thresh),
    .data_out(data_out), .data_out_en(data_out_en), .hs_out(hs_out), .vs_out(vs_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef int win_t [3][3];
  typedef struct {
    int mag;
    bit masked;
    bit hs;
    bit vs;
  } exp_t;

  function automatic int sobel_mag(input win_t w);
    int gx, gy;
    gx = (w[0][2] + 2*w[1][2] + w[2][2]) - (w[0][0] + 2*w[1][0] + w[2][0]);
    gy = (w[2][0] + 2*w[2][1] + w[2][2]) - (w[0][0] + 2*w[0][1] + w[0][2]);
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction

  function automatic int out_of(input int mag, input bit masked, input int thr);
    if (masked) return 0;
`ifdef SOBEL_MAG_OUT_EN
    return (mag > 255) ? 255 : mag;
`else
    return (mag >= thr) ? 255 : 0;
`endif
  endfunction

  // Model state
  exp_t q[$];
  int   img [3][W];
  int   idx = 0;
  bit   synced = 0;
  bit   vs_prev_m = 0;
  int   thr_m = TR;
  int   cur_data = 0;
  bit   cur_en = 0, cur_hs = 0, cur_vs = 0;
  int   nz_cnt = 0;
  int   ln, cl;
  win_t wm;
  exp_t e, pe;

  // Model + per-cycle compare
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      idx = 0; synced = 0; vs_prev_m = 0; thr_m = TR;
      cur_data = 0; cur_en = 0; cur_hs = 0; cur_vs = 0;
    end else begin
      if (vs_in && !vs_prev_m) begin
        idx = 0; synced = 1; thr_m = thresh;
      end
      vs_prev_m = vs_in;
      if (data_in_en) begin
        ln = idx / W;
        cl = idx % W;
        img[ln % 3][cl] = data_in;
        e.masked = !synced || ln < 2 || cl < 2;
        e.mag = 0;
        if (!e.masked) begin
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              wm[r][c] = img[(ln - 2 + r) % 3][cl - 2 + c];
          e.mag = sobel_mag(wm);
        end
        e.hs = hs_in;
        e.vs = vs_in;
        q.push_back(e);
        idx++;
        if (q.size() == 3) begin
          pe = q.pop_front();
          cur_data = out_of(pe.mag, pe.masked, thr_m);
          cur_en = 1; cur_hs = pe.hs; cur_vs = pe.vs;
          if (cur_data != 0) nz_cnt++;
        end
      end
    end
    #1;
    chk("cycle_out", {21'd0, data_out_en, hs_out, vs_out, data_out},
        {21'd0, cur_en, cur_hs, cur_vs, cur_data[7:0]});
  end

  function automatic logic [7:0] pix(input int kind, input int amp, input int l, input int c);
    case (kind)
      0: return amp[7:0];
      1: return (c >= 8) ? amp[7:0] : 8'd0;
      default: return (l == 2 && c == 5) ? amp[7:0] : 8'd0;
    endcase
  endfunction

  task automatic do_reset();
    data_in_en = 0; hs_in = 0; vs_in = 0;
    #2 rst = 1;
    #1;
    chk("rst_async_out", {data_out_en, hs_out, vs_out, data_out}, 0);
    chk("rst_thresh", dut.thresh_q, TR);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  // One frame of H lines plus three trailing pixels of line H (pushes the
  // last results out without introducing new edges).
  task automatic run_frame(input int kind, input int amp, input int h,
                           input logic [7:0] thr0, input logic [7:0] thr1, input int mid_line,
                           input bit toggle, input int rst_line, input int rst_col);
    int cmax;
    repeat (2) begin
      @(negedge clk);
      data_in_en = 0; hs_in = 0; vs_in = 0;
    end
    for (int l = 0; l <= h; l++) begin
      cmax = (l == h) ? 3 : W;
      for (int c = 0; c < cmax; c++) begin
        if (toggle) begin
          @(negedge clk);
          data_in_en = 0; hs_in = 0; vs_in = 0; data_in = 8'hA5;
        end
        @(negedge clk);
        if (l == rst_line && c == rst_col) do_reset();
        data_in = pix(kind, amp, l, c);
        data_in_en = 1;
        hs_in = (c == 0);
        vs_in = (l == 0 && c == 0);
        if (l == 0 && c == 0) thresh = thr0;
        if (l == mid_line && l != 0 && c == 0) thresh = thr1;
      end
    end
    @(negedge clk);
    data_in_en = 0; hs_in = 0; vs_in = 0;
  endtask

  win_t pin_w;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_out", {data_out_en, hs_out, vs_out, data_out}, 0);
    chk("reset_thresh", dut.thresh_q, TR);
    rst = 0;

    // Hand-computed pins of the model
    pin_w = '{'{0, 0, 200}, '{0, 0, 200}, '{0, 0, 200}};
    chk("pin_step_mag", sobel_mag(pin_w), 800);
    pin_w = '{'{0, 255, 0}, '{0, 0, 0}, '{0, 0, 0}};
    chk("pin_impulse_top", sobel_mag(pin_w), 510);
    pin_w = '{'{0, 0, 0}, '{0, 255, 0}, '{0, 0, 0}};
    chk("pin_impulse_ctr", sobel_mag(pin_w), 0);

    nz_cnt = 0; run_frame(0, 100, 4, 8'd64, 8'd64, -1, 0, -1, -1);
    chk("flat_nz", nz_cnt, 0);
    nz_cnt = 0; run_frame(1, 200, 4, 8'd64, 8'd64, -1, 0, -1, -1);
    chk("step_nz", nz_cnt, 4);
    nz_cnt = 0; run_frame(1, 200, 4, 8'd64, 8'd250, 2, 0, -1, -1);
    chk("thr_mid250_nz", nz_cnt, 4);
    nz_cnt = 0; run_frame(1, 200, 4, 8'd250, 8'd250, -1, 0, -1, -1);
    chk("thr_250_nz", nz_cnt, 4);
    nz_cnt = 0; run_frame(1, 30, 4, 8'd64, 8'd255, 2, 0, -1, -1);
    chk("thr_mid255_nz", nz_cnt, 4);
    nz_cnt = 0; run_frame(1, 30, 4, 8'd255, 8'd255, -1, 0, -1, -1);
`ifdef SOBEL_MAG_OUT_EN
    chk("thr_255_nz", nz_cnt, 4);
`else
    chk("thr_255_nz", nz_cnt, 0);
`endif
    nz_cnt = 0; run_frame(1, 200, 4, 8'd64, 8'd64, -1, 1, -1, -1);
    chk("toggle_nz", nz_cnt, 4);
    nz_cnt = 0; run_frame(1, 200, 8, 8'd250, 8'd250, -1, 0, 5, 6);
    chk("rst_frame_nz", nz_cnt, 6);
    nz_cnt = 0; run_frame(1, 200, 4, 8'd64, 8'd64, -1, 0, -1, -1);
    chk("post_rst_nz", nz_cnt, 4);
    nz_cnt = 0; run_frame(2, 255, 4, 8'd64, 8'd64, -1, 0, -1, -1);
    chk("impulse_nz", nz_cnt, 5);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
